gray_sobel_edge: RTL
====================

Name: gray_sobel_edge

Overview:
- Consumes the 8-bit grayscale pixel stream (din/vld/sop/eop) from the RGB565-to-gray stage.
- Forms a 3x3 window using two internal line buffers.
- Computes the Sobel gradient magnitude |Gx|+|Gy| and emits a saturated magnitude plus a thresholded binary edge pixel, on the same stream protocol, to the frame-buffer/display path.
- Output pixel count equals input pixel count. The result is the image shifted one pixel down-right, with incomplete-window borders forced to zero.

Parameters:
IMG_W, 640, pixels per line (line-buffer depth and column wrap point)
THRESH, 100, edge threshold compared against the unsaturated 11-bit magnitude

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
din  input  8  gray pixel, valid when din_vld=1
din_vld  input  1  input pixel strobe
din_sop  input  1  first pixel of frame, qualified by din_vld
din_eop  input  1  last pixel of frame, qualified by din_vld
dout  output  8  255 if magnitude >= THRESH, else 0
dout_mag  output  8  magnitude saturated to 255
dout_vld  output  1  output pixel strobe
dout_sop  output  1  din_sop delayed 3 cycles
dout_eop  output  1  din_eop delayed 3 cycles

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. All outputs, counters, window registers and pipeline registers reset to 0. Line-buffer contents are not reset; border masking covers stale data.
- No backpressure. The pipeline advances every cycle. vld/sop/eop pass through a 3-deep shift register clocked unconditionally.
- Latency is exactly 3 clk: din_vld at cycle T gives dout_vld at T+3. Gaps in din_vld are preserved one-for-one.
- Counters: col (0..IMG_W-1) and row (saturating, at least 11 bits).
  - On din_vld & din_sop: the current pixel is treated as col=0, row=0, and the counters then advance from it.
  - On any other din_vld: col increments. At col=IMG_W-1 it wraps to 0 and row increments.
  - din_eop does not alter the counters. A sop in mid-frame resynchronises immediately.
- Stage 1 (on din_vld only):
  - The window shifts left.
  - The new right column is {top=lb1[col], mid=lb0[col], bot=din}.
  - lb1[col]<=lb0[col] and lb0[col]<=din, read-before-write at the same address.
  - win_ok is registered as (row>=2 && col>=2), using the counter values for this pixel.
- Stage 2 (registered every cycle):
  - Gx = (p02+2p12+p22)-(p00+2p10+p20).
  - Gy = (p20+2p21+p22)-(p00+2p01+p02).
  - Both are 11-bit signed; |Gx| and |Gy| are stored as 10-bit unsigned, maximum 1020.
  - win_ok is delayed alongside.
- Stage 3 (registered):
  - mag = |Gx|+|Gy|, 11-bit, maximum 2040.
  - dout_mag = (mag>255) ? 255 : mag[7:0].
  - dout = (mag>=THRESH) ? 255 : 0.
  - If win_ok=0, both dout and dout_mag are 0.
- dout/dout_mag hold their last value while dout_vld=0. Consumers only sample on dout_vld.
- Reset mid-frame: outputs return to 0 immediately. The next frame must start with sop.
- IMG_W must be >= 3.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> dout, dout_mag, dout_vld, dout_sop and dout_eop all 0 within the same cycle; after release, no dout_vld until din_vld is seen.
- Flat frame, IMG_W=8, 8x8 pixels all 128, continuous vld -> 64 dout_vld pulses, each 3 cycles after its input; all dout=0 and dout_mag=0; dout_sop on the 1st output, dout_eop on the 64th.
- Vertical step, IMG_W=8, columns 0-3=0 and 4-7=255, 8 rows -> outputs with row>=2 and col in {4,5} give dout_mag=255 (mag=1020) and dout=255; every other output is 0 (rows 0-1 and cols 0-1 are masked).
- Threshold edge, THRESH=200, pixel value = col*25 -> interior |Gx|=200 gives dout=255 and dout_mag=200; repeating with col*24 gives mag=192, dout=0 and dout_mag=192.
- Gappy input: the vertical-step frame with din_vld randomly at 50% -> dout sequence identical to the continuous run; each dout_vld lands exactly 3 cycles after its din_vld.
- Mid-frame resync, IMG_W=8: assert sop on the 21st pixel -> that pixel becomes row0/col0; the next 16 outputs and cols 0-1 of later rows are 0; total output count equals input count.

Source files
------------

// File: rtl/gray_sobel_edge.sv
// gray_sobel_edge
//   Sobel edge detector for an 8-bit grayscale pixel stream. A 3x3 window is
//   built from two line buffers plus a 3-column shift window. The gradient
//   magnitude |Gx|+|Gy| is emitted saturated to 8 bits, alongside a
//   thresholded binary edge pixel. The result is the image shifted one pixel
//   down-right. Windows that are not yet complete (row<2 or col<2) are forced
//   to zero.
//   Fixed latency of 3 clk. There is no backpressure.
//
// Parameters
//   IMG_W   pixels per line (>= 3): line-buffer depth and column wrap point
//   THRESH  edge threshold, compared against the unsaturated 11-bit magnitude
//
// Ports
//   clk, rst_n                      pixel clock, async active-low reset
//   din, din_vld, din_sop, din_eop  input gray pixel stream
//   dout                            255 if magnitude >= THRESH, else 0
//   dout_mag                        magnitude saturated to 255
//   dout_vld, dout_sop, dout_eop    input strobes delayed 3 clk
module gray_sobel_edge #(
   parameter int IMG_W  = 640,
   parameter int THRESH = 100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] din,
   input  logic       din_vld,
   input  logic       din_sop,
   input  logic       din_eop,
   output logic [7:0] dout,
   output logic [7:0] dout_mag,
   output logic       dout_vld,
   output logic       dout_sop,
   output logic       dout_eop
);

   localparam int STAGES = 3;
   localparam int CW     = $clog2(IMG_W);
   localparam int RW     = 11;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [10:0]   THR      = 11'(THRESH);

   // Weighted column/row sum a + 2b + c (max 1020).
   function automatic logic [10:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
      return {3'b0, a} + {2'b0, b, 1'b0} + {3'b0, c};
   endfunction

   // |v| for an 11-bit two's-complement value in -1020..1020.
   function automatic logic [9:0] abs10(input logic [10:0] v);
      logic [10:0] n;
      n = v[10] ? (11'd0 - v) : v;
      return n[9:0];
   endfunction

   // Strobe pipeline; index k holds the strobe k cycles after input.
   logic [STAGES:1] vld_pipe, sop_pipe, eop_pipe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         sop_pipe <= '0;
         eop_pipe <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], din_vld};
         sop_pipe <= {sop_pipe[STAGES-1:1], din_vld & din_sop};
         eop_pipe <= {eop_pipe[STAGES-1:1], din_vld & din_eop};
      end
   end

   assign dout_vld = vld_pipe[STAGES];
   assign dout_sop = sop_pipe[STAGES];
   assign dout_eop = eop_pipe[STAGES];

   // Position counters. col/row hold the position of the *next* pixel.
   // A sop forces the current pixel to (0,0), so a mid-frame sop
   // resynchronises on the pixel that carries it.
   logic [CW-1:0] col, cur_col;
   logic [RW-1:0] row, cur_row;

   assign cur_col = din_sop ? '0 : col;
   assign cur_row = din_sop ? '0 : row;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (din_vld) begin
         if (cur_col == COL_LAST) begin
            col <= '0;
            row <= (&cur_row) ? cur_row : cur_row + 1'b1;
         end else begin
            col <= cur_col + 1'b1;
            row <= cur_row;
         end
      end
   end

   // Line buffers: lb0 holds the previous line and lb1 the line before it.
   // They are deliberately not reset; stale content only ever reaches
   // masked (row<2) windows.
   logic [7:0] lb0 [IMG_W];
   logic [7:0] lb1 [IMG_W];

   always_ff @(posedge clk) begin
      if (din_vld) begin
         lb1[cur_col] <= lb0[cur_col];
         lb0[cur_col] <= din;
      end
   end

   // Stage 1: the window is indexed win[row][col]. Row 0 is the top row and
   // col 2 is the newest column.
   logic [2:0][2:0][7:0] win;
   logic                 ok1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win <= '0;
         ok1 <= 1'b0;
      end else if (din_vld) begin
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
         win[0][2] <= lb1[cur_col];
         win[1][2] <= lb0[cur_col];
         win[2][2] <= din;
         ok1       <= (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      end
   end

   // Stage 2: gradients. The differences of two 10-bit sums fit in 11-bit
   // signed arithmetic, so modular subtraction is exact.
   logic [10:0] gx, gy;
   logic [9:0]  abs_x, abs_y;
   logic        ok2;

   assign gx = wsum(win[0][2], win[1][2], win[2][2]) - wsum(win[0][0], win[1][0], win[2][0]);
   assign gy = wsum(win[2][0], win[2][1], win[2][2]) - wsum(win[0][0], win[0][1], win[0][2]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         abs_x <= '0;
         abs_y <= '0;
         ok2   <= 1'b0;
      end else begin
         abs_x <= abs10(gx);
         abs_y <= abs10(gy);
         ok2   <= ok1;
      end
   end

   // Stage 3: magnitude, saturation, threshold. Updates only for a valid
   // pixel, so the outputs hold between strobes.
   logic [10:0] mag;

   assign mag = {1'b0, abs_x} + {1'b0, abs_y};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout     <= '0;
         dout_mag <= '0;
      end else if (vld_pipe[STAGES-1]) begin
         dout_mag <= !ok2 ? 8'h00 : (mag > 11'd255) ? 8'hFF : mag[7:0];
         dout     <= (ok2 && (mag >= THR)) ? 8'hFF : 8'h00;
      end
   end

endmodule
